// File: rtl/cpu_pkg.sv
// Shared CPU definitions: context-engine state encoding and datapath widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } ctx_state_t;

  localparam int DATA_W      = 16;
  localparam int REG_ADDR_W  = 4;
  localparam int BANKED_REGS = 8;

endpackage

// File: rtl/reg_context_sequencer.sv
// Interrupt/trap context engine: pushes banked r0..r(N-1) onto a full-descending
// memory stack (SAVE) and pops them back into the register file (RESTORE).
module reg_context_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8  // 1..BANKED_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  save_req,
  input  logic                  restore_req,
  input  logic [DATA_W-1:0]     base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     sp_out,
  output logic [REG_ADDR_W-1:0] poke_addr,
  input  logic [DATA_W-1:0]     poke_data,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic                  rf_write_en,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  ctx_state_t        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] sp_q, sp_d;

  // Next-state and output decode; the register file write is Mealy on mem_ready.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sp_d          = sp_q;
    busy          = 1'b0;
    done          = 1'b0;
    sp_out        = sp_q;
    poke_addr     = {REG_ADDR_W{1'b0}};
    rf_write_addr = {REG_ADDR_W{1'b0}};
    rf_write_data = {DATA_W{1'b0}};
    rf_write_en   = 1'b0;
    mem_addr      = {DATA_W{1'b0}};
    mem_wdata     = {DATA_W{1'b0}};
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    case (state_q)
      IDLE: begin
        if (save_req) begin
          state_d = SAVE;
          sp_d    = base_addr;
          idx_d   = 3'd0;
        end else if (restore_req) begin
          state_d = RESTORE;
          sp_d    = base_addr;
          idx_d   = LAST_IDX;
        end else begin
          state_d = IDLE;
        end
      end
      SAVE: begin
        busy      = 1'b1;
        poke_addr = {1'b0, idx_q};
        mem_addr  = sp_q - 16'd1;
        mem_wdata = poke_data;
        mem_we    = 1'b1;
        if (mem_ready) begin
          sp_d = sp_q - 16'd1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = SAVE;
        end
      end
      RESTORE: begin
        busy     = 1'b1;
        mem_addr = sp_q;
        mem_re   = 1'b1;
        if (mem_ready) begin
          rf_write_en   = 1'b1;
          rf_write_addr = {1'b0, idx_q};
          rf_write_data = mem_rdata;
          sp_d          = sp_q + 16'd1;
          if (idx_q == 3'd0) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end else begin
          state_d = RESTORE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index and stack pointer registers; reset aborts any transfer in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      sp_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sp_q    <= sp_d;
    end
  end

endmodule

// File: tb/tb_reg_context_sequencer.sv
// Directed bench: scoreboard of expected memory transfers, memory/register-file models.
module tb_reg_context_sequencer;

  logic        clock = 1'b0;
  logic        reset, save_req, restore_req;
  logic [15:0] base_addr;
  logic        busy, done;
  logic [15:0] sp_out;
  logic [3:0]  poke_addr;
  logic [15:0] poke_data;
  logic [3:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        rf_write_en;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  rnum;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];
  int          checks = 0;
  int          errors = 0;
  int          xfer_cnt = 0;
  int          stall_cnt = 0;
  bit          stall_en = 1'b0;
  bit          mon_en = 1'b0;
  bit          hold_valid = 1'b0;
  logic [15:0] hold_addr, hold_wdata;
  logic        hold_we, hold_re;

  always #5 clock = ~clock;

  assign poke_data = rf[poke_addr[2:0]];

  reg_context_sequencer #(.NUM_REGS(8)) dut (
    .clock(clock), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .base_addr(base_addr), .busy(busy), .done(done), .sp_out(sp_out),
    .poke_addr(poke_addr), .poke_data(poke_data),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder and transfer monitor: pops the scoreboard on each completed transfer.
  always @(negedge clock) begin
    mem_ready = stall_en ? (stall_cnt == 0) : 1'b1;
    mem_rdata = mem[mem_addr];
    #1;
    if (mon_en) begin
      if (mem_we || mem_re) begin
        if (hold_valid) begin
          check("stall_addr", mem_addr, hold_addr);
          check("stall_wdata", mem_wdata, hold_wdata);
          check("stall_we", mem_we, hold_we);
          check("stall_re", mem_re, hold_re);
        end
        if (mem_ready) begin
          xfer_t e;
          xfer_cnt++;
          hold_valid = 1'b0;
          stall_cnt  = $urandom_range(0, 3);
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("xfer_we", mem_we, e.we);
            check("xfer_addr", mem_addr, e.addr);
            if (e.we) begin
              check("xfer_wdata", mem_wdata, e.data);
              mem[mem_addr] = mem_wdata;
            end else begin
              check("rf_waddr", rf_write_addr, e.rnum);
              check("rf_wdata", rf_write_data, e.data);
              rf[rf_write_addr[2:0]] = rf_write_data;
            end
          end
        end else begin
          stall_cnt--;
          hold_valid = 1'b1;
          hold_addr  = mem_addr;
          hold_wdata = mem_wdata;
          hold_we    = mem_we;
          hold_re    = mem_re;
        end
      end else begin
        hold_valid = 1'b0;
      end
      check("rf_we_gate", rf_write_en, mem_re && mem_ready);
    end
  end

  task automatic push_save(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      xfer_t e;
      e.we = 1'b1; e.addr = base - 16'(i + 1); e.data = rf[i]; e.rnum = 4'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_restore(input logic [15:0] base, input logic [15:0] v0);
    for (int i = 7; i >= 0; i--) begin
      xfer_t e;
      e.we = 1'b0; e.addr = base + 16'(7 - i); e.data = v0 + 16'(i); e.rnum = 4'(i);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; request is sampled at the following posedge (edge k).
  task automatic start_op(input bit sv, input bit rs, input logic [15:0] base);
    xfer_cnt    = 0;
    save_req    = sv;
    restore_req = rs;
    base_addr   = base;
    @(posedge clock);
    #1;
    save_req    = 1'b0;
    restore_req = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clock);
      if (n == 1) check("busy_after_req", busy, 1'b1);
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_op(input string tag, input logic [15:0] exp_sp);
    check({tag, "_sp_out"}, sp_out, exp_sp);
    check({tag, "_xfers"}, xfer_cnt, 32'd8);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_sp_hold"}, sp_out, exp_sp);
  endtask

  initial begin
    int lat;
    int pulses;
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0; base_addr = 16'd0;
    mem_ready = 1'b1; mem_rdata = 16'd0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h1110 + 16'(i);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sp_out", sp_out, 16'h0000);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_rf_we", rf_write_en, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_poke_addr", poke_addr, 4'h0);
    mon_en = 1'b1;

    // 1: save with zero wait states
    push_save(16'h8000);
    start_op(1'b1, 1'b0, 16'h8000);
    wait_done(40, lat);
    check("t1_latency", lat, 32'd9);
    for (int i = 0; i < 8; i++) check("t1_image", mem[16'h7FFF - 16'(i)], 16'h1110 + 16'(i));
    finish_op("t1", 16'h7FF8);

    // 2: restore the image into a cleared register file
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    push_restore(16'h7FF8, 16'h1110);
    start_op(1'b0, 1'b1, 16'h7FF8);
    wait_done(40, lat);
    check("t2_latency", lat, 32'd9);
    for (int i = 0; i < 8; i++) check("t2_rf", rf[i], 16'h1110 + 16'(i));
    finish_op("t2", 16'h8000);

    // 3: same round trip with random stalls
    stall_en = 1'b1;
    for (int i = 0; i < 8; i++) mem[16'h7FF8 + 16'(i)] = 16'h0000;
    push_save(16'h8000);
    start_op(1'b1, 1'b0, 16'h8000);
    wait_done(200, lat);
    finish_op("t3s", 16'h7FF8);
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    push_restore(16'h7FF8, 16'h1110);
    start_op(1'b0, 1'b1, 16'h7FF8);
    wait_done(200, lat);
    for (int i = 0; i < 8; i++) check("t3_rf", rf[i], 16'h1110 + 16'(i));
    finish_op("t3r", 16'h8000);
    stall_en = 1'b0;
    @(negedge clock);

    // 4: stack pointer wraps below zero
    for (int i = 0; i < 8; i++) rf[i] = 16'hA0A0 + 16'(i);
    push_save(16'h0003);
    start_op(1'b1, 1'b0, 16'h0003);
    wait_done(40, lat);
    check("t4_mem_0000", mem[16'h0000], 16'hA0A2);
    check("t4_mem_FFFB", mem[16'hFFFB], 16'hA0A7);
    finish_op("t4", 16'hFFFB);

    // 5: simultaneous requests pick SAVE; a restore pulse mid-SAVE is dropped
    push_save(16'h5000);
    start_op(1'b1, 1'b1, 16'h5000);
    pulses = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clock);
      if (n == 3) restore_req = 1'b1;
      if (n == 4) restore_req = 1'b0;
      if (done) pulses++;
    end
    check("t5_done_pulses", pulses, 32'd1);
    check("t5_xfers", xfer_cnt, 32'd8);
    check("t5_queue_empty", exp_q.size(), 32'd0);
    check("t5_idle", busy, 1'b0);
    check("t5_sp_out", sp_out, 16'h4FF8);

    // 6: reset while SAVE is transferring r4, then restart
    push_save(16'h6000);
    start_op(1'b1, 1'b0, 16'h6000);
    for (int n = 1; n <= 5; n++) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t6_busy", busy, 1'b0);
    check("t6_mem_we", mem_we, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_sp_out", sp_out, 16'h0000);
    check("t6_partial", exp_q.size(), 32'd3);
    exp_q.delete();
    push_save(16'h6000);
    start_op(1'b1, 1'b0, 16'h6000);
    wait_done(40, lat);
    check("t6_latency", lat, 32'd9);
    finish_op("t6", 16'h5FF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
